// File: rtl/imm_ext_pipe_pkg.sv
// Shared op codes and skid-buffer state encoding for the immediate generator.
// The SE/ZE/LS/NOP values match the original codes so the control decoder stays unchanged.
package imm_ext_pipe_pkg;

    localparam int EXT_OP_W = 3;

    localparam logic [EXT_OP_W-1:0] EXT_OP_SE  = 3'd0;
    localparam logic [EXT_OP_W-1:0] EXT_OP_ZE  = 3'd1;
    localparam logic [EXT_OP_W-1:0] EXT_OP_LS  = 3'd2;
    localparam logic [EXT_OP_W-1:0] EXT_OP_NOP = 3'd3;
    localparam logic [EXT_OP_W-1:0] EXT_OP_BR  = 3'd4;
    localparam logic [EXT_OP_W-1:0] EXT_OP_JT  = 3'd5;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_ext_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid register with synchronous flush.
// The output register always holds the oldest entry; the skid register holds the second.
module imm_ext_pipe_skid_buf
    import imm_ext_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data
);

    skid_state_t  r_state;
    skid_state_t  w_state_next;
    logic [W-1:0] r_out_data;
    logic [W-1:0] r_skid_data;
    logic         w_accept;
    logic         w_xfer;
    logic         w_load_out_in;
    logic         w_load_out_skid;
    logic         w_load_skid;

    assign o_in_ready  = (r_state != SKID_TWO);
    assign o_out_valid = (r_state != SKID_EMPTY);
    assign o_out_data  = r_out_data;
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_xfer      = o_out_valid && i_out_ready;

    always_comb begin
        w_state_next    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        if (i_flush) begin
            // A same-cycle accept is dropped along with everything buffered.
            w_state_next = SKID_EMPTY;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_accept) begin
                        w_state_next  = SKID_ONE;
                        w_load_out_in = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (w_accept && !w_xfer) begin
                        w_state_next = SKID_TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_accept && w_xfer) begin
                        w_load_out_in = 1'b1;
                    end else if (w_xfer) begin
                        w_state_next = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (w_xfer) begin
                        w_state_next    = SKID_ONE;
                        w_load_out_skid = 1'b1;
                    end
                end
                default: w_state_next = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SKID_EMPTY;
            r_out_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_out_in) begin
                r_out_data <= i_in_data;
            end else if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
            end
        end
    end

    // Skid contents are meaningless unless state is TWO, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid_data <= i_in_data;
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate generator for the decode->execute boundary: combinational
// extension ahead of a 2-entry skid buffer carrying {err, tag, data}.
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26,
    parameter int TAG_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXT_OP_W-1:0] in_op,
    input  logic [IMM_W-1:0]    in_imm,
    input  logic [JIDX_W-1:0]   in_jidx,
    input  logic [DATA_W-1:0]   in_pc,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
);

    localparam int S   = DATA_W - IMM_W;
    localparam int PKT = 1 + TAG_W + DATA_W;

    logic [DATA_W-1:0] w_se;
    logic [DATA_W-1:0] w_data;
    logic              w_err;
    logic [PKT-1:0]    w_pkt_in;
    logic [PKT-1:0]    w_pkt_out;

    assign w_se = {{S{in_imm[IMM_W-1]}}, in_imm};

    always_comb begin
        w_data = '0;
        w_err  = 1'b0;
        case (in_op)
            EXT_OP_SE:  w_data = w_se;
            EXT_OP_ZE:  w_data = {{S{1'b0}}, in_imm};
            EXT_OP_LS:  w_data = {in_imm, {S{1'b0}}};
            EXT_OP_NOP: w_data = '0;
            // Top two bits of the sign-extended value fall off; no overflow is reported.
            EXT_OP_BR:  w_data = w_se << 2;
            EXT_OP_JT:  w_data = {in_pc[DATA_W-1:JIDX_W+2], in_jidx, 2'b00};
            default:    w_err  = 1'b1;
        endcase
    end

    assign w_pkt_in = {w_err, in_tag, w_data};

    imm_ext_pipe_skid_buf #(
        .W (PKT)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (w_pkt_in),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (w_pkt_out)
    );

    assign out_err  = w_pkt_out[PKT-1];
    assign out_tag  = w_pkt_out[DATA_W +: TAG_W];
    assign out_data = w_pkt_out[DATA_W-1:0];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed mode vectors, back-pressure,
// flush, undefined ops, async reset and a randomized scoreboard run.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_jidx = 26'd0;
    logic [31:0] in_pc = 32'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } result_t;

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_imm    (in_imm),
        .in_jidx   (in_jidx),
        .in_pc     (in_pc),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    // Reference: arithmetic form of each mode, independent of bit-slicing.
    function automatic result_t model(logic [2:0] op, logic [15:0] im, logic [25:0] j,
                                      logic [31:0] pc, logic [4:0] tag);
        result_t r;
        int signed s;
        logic [31:0] u;
        s = im[15] ? int'(im) - 65536 : int'(im);
        u = 32'(im);
        r.tag = tag;
        r.err = 1'b0;
        case (op)
            3'd0: r.data = 32'(s);
            3'd1: r.data = u;
            3'd2: r.data = u * 32'd65536;
            3'd3: r.data = 32'd0;
            3'd4: r.data = 32'(s * 4);
            3'd5: r.data = (pc & 32'hF000_0000) | (32'(j) * 32'd4);
            default: begin
                r.data = 32'd0;
                r.err  = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [2:0] op, logic [15:0] im, logic [25:0] j,
                         logic [31:0] pc, logic [4:0] tag);
        in_valid = v;
        in_op    = op;
        in_imm   = im;
        in_jidx  = j;
        in_pc    = pc;
        in_tag   = tag;
    endtask

    task automatic test_reset;
        #3;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_tag !== 5'd0 ||
            out_err !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: got v=%b d=%h t=%h e=%b rdy=%b, want 0/0/0/0/1",
                     out_valid, out_data, out_tag, out_err, in_ready);
        end
        #4 rst_n = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: out_valid got=%b want=0", out_valid);
        end
    endtask

    task automatic test_modes;
        logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [15:0] ims [6] = '{16'h8004, 16'h8004, 16'h1234, 16'h5A5A, 16'hFFFF, 16'h0000};
        logic [31:0] exp [6] = '{32'hFFFF8004, 32'h00008004, 32'h12340000, 32'h0,
                                 32'hFFFFFFFC, 32'hA0000400};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], ims[i], 26'h0000100, 32'hA0000010, 5'(i + 3));
            step();
            drive(1'b0, 3'd0, 16'd0, 26'd0, 32'd0, 5'd0);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_err !== 1'b0 ||
                out_tag !== 5'(i + 3)) begin
                bad++;
                $display("FAIL mode op=%0d: got v=%b d=%h e=%b t=%h, want 1/%h/0/%h",
                         ops[i], out_valid, out_data, out_err, out_tag, exp[i], 5'(i + 3));
            end
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mode_drain op=%0d: out_valid got=%b want=0", ops[i], out_valid);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp [3] = '{32'h00000011, 32'h00000022, 32'h00000033};
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h0011, 26'd0, 32'd0, 5'd1);
        step();
        total++;
        if (in_ready !== 1'b1 || out_data !== exp[0]) begin
            bad++;
            $display("FAIL b2b_first: rdy=%b d=%h, want 1/%h", in_ready, out_data, exp[0]);
        end
        drive(1'b1, 3'd1, 16'h0022, 26'd0, 32'd0, 5'd2);
        step();
        drive(1'b1, 3'd1, 16'h0033, 26'd0, 32'd0, 5'd3);
        total++;
        if (in_ready !== 1'b0 || out_data !== exp[0] || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_full: rdy=%b v=%b d=%h, want 0/1/%h",
                     in_ready, out_valid, out_data, exp[0]);
        end
        step();
        total++;
        if (in_ready !== 1'b0 || out_data !== exp[0]) begin
            bad++;
            $display("FAIL b2b_hold: rdy=%b d=%h, want 0/%h", in_ready, out_data, exp[0]);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            step();
            if (i == 2) drive(1'b0, 3'd0, 16'd0, 26'd0, 32'd0, 5'd0);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i] || out_tag !== 5'(i + 1)) begin
                bad++;
                $display("FAIL b2b_drain%0d: v=%b d=%h t=%h, want 1/%h/%h",
                         i, out_valid, out_data, out_tag, exp[i], 5'(i + 1));
            end
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_empty: out_valid got=%b want=0", out_valid);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h00A1, 26'd0, 32'd0, 5'd1);
        step();
        drive(1'b1, 3'd1, 16'h00A2, 26'd0, 32'd0, 5'd2);
        step();
        drive(1'b1, 3'd1, 16'h00D0, 26'd0, 32'd0, 5'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'd0, 26'd0, 32'd0, 5'd0);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush: v=%b rdy=%b, want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_ghost: out_valid=%b d=%h, want 0", out_valid, out_data);
            end
        end
        drive(1'b1, 3'd1, 16'h00E5, 26'd0, 32'd0, 5'd7);
        step();
        drive(1'b0, 3'd0, 16'd0, 26'd0, 32'd0, 5'd0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h000000E5) begin
            bad++;
            $display("FAIL flush_resume: v=%b d=%h, want 1/000000e5", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_undef;
        logic [2:0] ops [2] = '{3'd7, 3'd6};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ops[i], 16'hBEEF, 26'h3FFFFFF, 32'hFFFFFFFF, 5'h15 + 5'(i));
            step();
            drive(1'b0, 3'd0, 16'd0, 26'd0, 32'd0, 5'd0);
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'd0 || out_err !== 1'b1 ||
                out_tag !== 5'h15 + 5'(i)) begin
                bad++;
                $display("FAIL undef op=%0d: v=%b d=%h e=%b t=%h, want 1/0/1/%h",
                         ops[i], out_valid, out_data, out_err, out_tag, 5'h15 + 5'(i));
            end
            step();
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h1111, 26'd0, 32'd0, 5'd4);
        step();
        step();
        drive(1'b0, 3'd0, 16'd0, 26'd0, 32'd0, 5'd0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0 || out_tag !== 5'd0) begin
            bad++;
            $display("FAIL async_reset: v=%b rdy=%b d=%h t=%h, want 0/1/0/0",
                     out_valid, in_ready, out_data, out_tag);
        end
        step();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_after: out_valid got=%b want=0", out_valid);
        end
    endtask

    task automatic test_random;
        result_t     q[$];
        result_t     e;
        logic        hold;
        logic [31:0] h_data;
        logic [4:0]  h_tag;
        logic        h_err;
        logic [2:0]  op;
        hold = 1'b0;
        h_data = '0;
        h_tag = '0;
        h_err = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            total++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
                bad++;
                $display("FAIL rand_occ c=%0d: rdy=%b v=%b, occupancy=%0d",
                         c, in_ready, out_valid, q.size());
            end
            if (hold) begin
                total++;
                if (out_data !== h_data || out_tag !== h_tag || out_err !== h_err) begin
                    bad++;
                    $display("FAIL rand_stable c=%0d: got %h/%h/%b want %h/%h/%b",
                             c, out_data, out_tag, out_err, h_data, h_tag, h_err);
                end
            end
            op = 3'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 99) < 60), op, 16'($urandom), 26'($urandom),
                  $urandom, 5'($urandom));
            out_ready = 1'($urandom_range(0, 99) < 55);
            if (out_valid && out_ready) begin
                e = q.pop_front();
                total++;
                if (out_data !== e.data || out_tag !== e.tag || out_err !== e.err) begin
                    bad++;
                    $display("FAIL rand_xfer c=%0d: got %h/%h/%b want %h/%h/%b",
                             c, out_data, out_tag, out_err, e.data, e.tag, e.err);
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(in_op, in_imm, in_jidx, in_pc, in_tag));
            hold   = out_valid && !out_ready;
            h_data = out_data;
            h_tag  = out_tag;
            h_err  = out_err;
            step();
        end
        drive(1'b0, 3'd0, 16'd0, 26'd0, 32'd0, 5'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            e = q.pop_front();
            total++;
            if (out_valid !== 1'b1 || out_data !== e.data || out_tag !== e.tag) begin
                bad++;
                $display("FAIL rand_tail: v=%b d=%h t=%h want 1/%h/%h",
                         out_valid, out_data, out_tag, e.data, e.tag);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_flush();
        test_undef();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
